pb_color_cycler: RTL
====================

PB_COLOR_CYCLER -- requirements
Module: pb_color_cycler

Interface
REQ-001 Parameter N_CH, default 3: number of independent push-button channels (>=1).
REQ-002 Parameter N_COLORS, default 6: colour indices per channel, range 0..N_COLORS-1 (>=2).
REQ-003 Parameter TICK_DIV, default 50000: CLK cycles per lockout tick (1 ms at 50 MHz); >=2.
REQ-004 Parameter LOCKOUT_TICKS, default 200: ticks a channel ignores its button after an accepted press (>=1).
REQ-005 Localparam IW = max(1, clog2(N_COLORS)): index width.
REQ-006 CLK  input  1  sole clock, all state on rising edge.
REQ-007 RESETN  input  1  asynchronous, active-low reset.
REQ-008 btn  input  N_CH  raw asynchronous buttons, bit i = channel i, active high.
REQ-009 dir  input  1  0 = step up, 1 = step down; sampled at the accept edge.
REQ-010 clear  input  1  synchronous clear of all indices, active high.
REQ-011 idx  output  N_CH*IW  packed indices, channel i at bits [i*IW +: IW], registered.
REQ-012 press_pulse  output  N_CH  one-CLK pulse per accepted press, registered.
REQ-013 all_equal  output  1  registered, high when all channel indices are equal.
REQ-014 match_idx  output  IW  channel-0 index when all_equal, else 0, registered.

Function
REQ-015 Tick generator: counter 0..TICK_DIV-1, wraps to 0; tick is high for the one CLK cycle in which the counter equals TICK_DIV-1.
REQ-016 Each btn bit passes through a 2-flop synchronizer; the FSM sees only the second-stage value (btn_s).
REQ-017 Per-channel FSM has states IDLE, LOCK, WAIT_REL; reset state is IDLE.
REQ-018 IDLE & btn_s=1: accept press; step idx; press_pulse=1 for exactly one cycle; load lock counter with LOCKOUT_TICKS; go to LOCK.
REQ-019 LOCK: decrement the lock counter on each tick; when it reaches 0, go to WAIT_REL; btn ignored throughout.
REQ-020 WAIT_REL: btn_s=0 -> IDLE; btn_s=1 -> stay. A held button never re-triggers.
REQ-021 Latency: btn high sampled at edge k -> idx/press_pulse update at edge k+2.
REQ-022 Step up: N_COLORS-1 wraps to 0. Step down: 0 wraps to N_COLORS-1. No value >= N_COLORS ever appears.
REQ-023 Lockout duration is LOCKOUT_TICKS ticks; the first tick can be partial, so the window is (LOCKOUT_TICKS-1)*TICK_DIV+1 .. LOCKOUT_TICKS*TICK_DIV CLK cycles.
REQ-024 clear=1 forces every idx to 0 on that edge and has priority over any same-cycle step.
REQ-025 A press accepted in a clear cycle still pulses press_pulse and enters LOCK; idx stays 0.
REQ-026 clear does not alter FSM state, lock counters or the tick counter.
REQ-027 Channels are fully independent; simultaneous presses on several channels each step in the same cycle.
REQ-028 Lock counter width is clog2(LOCKOUT_TICKS+1).
REQ-029 all_equal and match_idx are computed from the registered idx; they lag idx by one cycle.
REQ-030 N_CH=1: all_equal is constantly 1 and match_idx follows idx with one-cycle lag.

Reset
REQ-031 RESETN=0 asynchronously sets: idx all 0; press_pulse 0; all_equal 1; match_idx 0; FSMs IDLE; tick and lock counters 0; synchronizer flops 0.
REQ-032 Reset asserted mid-LOCK or mid-WAIT_REL aborts the lockout.
REQ-033 After release, a still-held button is accepted as a new press once it has passed the synchronizer (2 edges).

Verification (TICK_DIV=4, LOCKOUT_TICKS=3, N_CH=3, N_COLORS=6)
REQ-034 btn[0] rises and holds 40 cycles, dir=0 -> idx ch0 goes 0->1 two edges after sampling; single press_pulse[0]; no further step while held.
REQ-035 Six separate press/release cycles on ch1, each >=13 cycles apart, dir=0 -> idx ch1 sequence 1,2,3,4,5,0.
REQ-036 dir=1, one press on ch2 from 0 -> idx ch2=5; a bounce train (on/off every cycle for 10 cycles) -> exactly one step.
REQ-037 Press ch0 and ch1 in the same cycle with clear=1 -> both press_pulse set, all idx 0, all_equal stays 1.
REQ-038 Step ch0, ch1 and ch2 each once -> all_equal=1 and match_idx=1 one cycle after the last idx update; step ch0 again -> all_equal=0, match_idx=0.
REQ-039 RESETN pulsed low during LOCK with btn held -> outputs at reset values immediately; a new step occurs 2 edges after release.

Source files
------------

// File: rtl/pb_color_cycler.sv
// Push-button colour cycler: per-channel synchronised, locked-out button
// presses step a wrapping colour index up or down; equality of all indices is reported.
module pb_color_cycler #(
  parameter  int N_CH          = 3,
  parameter  int N_COLORS      = 6,
  parameter  int TICK_DIV      = 50000,
  parameter  int LOCKOUT_TICKS = 200,
  localparam int IW            = (N_COLORS > 2) ? $clog2(N_COLORS) : 1
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [N_CH-1:0]      btn,
  input  logic                 dir,
  input  logic                 clear,
  output logic [N_CH*IW-1:0]   idx,
  output logic [N_CH-1:0]      press_pulse,
  output logic                 all_equal,
  output logic [IW-1:0]        match_idx
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = $clog2(LOCKOUT_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCK     = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  logic [TW-1:0]   tick_cnt_r;
  logic            tick_s;
  logic [N_CH-1:0] sync1_r;
  logic [N_CH-1:0] btn_s;
  logic            eq_s;

  assign tick_s = (tick_cnt_r == TW'(TICK_DIV - 1));

  // free-running lockout tick divider
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // two-flop synchroniser for the raw buttons
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_r <= {N_CH{1'b0}};
      btn_s   <= {N_CH{1'b0}};
    end else begin
      sync1_r <= btn;
      btn_s   <= sync1_r;
    end
  end

  genvar g;
  for (g = 0; g < N_CH; g++) begin : g_ch
    state_t          state_r;
    state_t          state_nxt_s;
    logic [LW-1:0]   lock_cnt_r;
    logic            accept_s;
    logic [IW-1:0]   idx_r;
    logic [IW-1:0]   step_s;
    logic            pulse_r;

    // channel FSM state register
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        state_r <= ST_IDLE;
      end else begin
        state_r <= state_nxt_s;
      end
    end

    // channel FSM next state; a held button parks in WAIT_REL
    always_comb begin
      state_nxt_s = state_r;
      case (state_r)
        ST_IDLE: begin
          if (btn_s[g]) state_nxt_s = ST_LOCK;
          else          state_nxt_s = ST_IDLE;
        end
        ST_LOCK: begin
          if ((lock_cnt_r == {LW{1'b0}}) || (tick_s && (lock_cnt_r == LW'(1))))
            state_nxt_s = ST_WAIT_REL;
          else
            state_nxt_s = ST_LOCK;
        end
        ST_WAIT_REL: begin
          if (btn_s[g]) state_nxt_s = ST_WAIT_REL;
          else          state_nxt_s = ST_IDLE;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end

    // channel FSM outputs: press acceptance and the wrapped next index
    always_comb begin
      accept_s = (state_r == ST_IDLE) && btn_s[g];
      if (dir) begin
        if (idx_r == {IW{1'b0}}) step_s = IW'(N_COLORS - 1);
        else                     step_s = idx_r - IW'(1);
      end else begin
        if (idx_r == IW'(N_COLORS - 1)) step_s = {IW{1'b0}};
        else                            step_s = idx_r + IW'(1);
      end
    end

    // lockout counter, decremented on ticks while locked
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        lock_cnt_r <= {LW{1'b0}};
      end else if (accept_s) begin
        lock_cnt_r <= LW'(LOCKOUT_TICKS);
      end else if ((state_r == ST_LOCK) && tick_s && (lock_cnt_r != {LW{1'b0}})) begin
        lock_cnt_r <= lock_cnt_r - LW'(1);
      end else begin
        lock_cnt_r <= lock_cnt_r;
      end
    end

    // index and press pulse; clear wins over a same-cycle step
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        idx_r   <= {IW{1'b0}};
        pulse_r <= 1'b0;
      end else begin
        pulse_r <= accept_s;
        if (clear)         idx_r <= {IW{1'b0}};
        else if (accept_s) idx_r <= step_s;
        else               idx_r <= idx_r;
      end
    end

    assign idx[g*IW +: IW] = idx_r;
    assign press_pulse[g]  = pulse_r;
  end

  // equality of the registered indices against channel 0
  always_comb begin
    eq_s = 1'b1;
    for (int i = 1; i < N_CH; i++) begin
      if (idx[i*IW +: IW] != idx[IW-1:0]) eq_s = 1'b0;
      else                                eq_s = eq_s;
    end
  end

  // registered equality flag and matching index
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      all_equal <= 1'b1;
      match_idx <= {IW{1'b0}};
    end else begin
      all_equal <= eq_s;
      match_idx <= eq_s ? idx[IW-1:0] : {IW{1'b0}};
    end
  end

endmodule
